// File: rtl/mem_mapped_io_sw.sv
// Memory-mapped slide-switch input port: synchronizes and debounces SW[7:0],
// latches per-bit change flags, and serves both over the CPU read bus.
module mem_mapped_io_sw #(
   parameter logic [8:0] SW_ADDR   = 9'h140,
   parameter int         DB_CYCLES = 50000,
   parameter int         CNT_W     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] SW,
   input  logic [8:0] mem_addr,
   input  logic [1:0] mem_cmd,
   input  logic [7:0] write_data,
   output logic [7:0] read_data,
   output logic       rd_drive
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
   localparam logic [8:0]       CHG_ADDR = SW_ADDR + 9'd1;

   logic [7:0]       r_s1;
   logic [7:0]       r_s2;
   logic [7:0]       r_db;
   logic [7:0]       r_chg;
   logic [CNT_W-1:0] r_cnt [8];

   logic             w_selData;
   logic             w_selChg;
   logic             w_wrChg;
   logic [7:0]       w_setMask;
   logic [7:0]       w_clrMask;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= 8'h00;
         r_s2 <= 8'h00;
      end else begin
         r_s1 <= SW;
         r_s2 <= r_s1;
      end
   end

   // A bit is accepted on the edge where it has disagreed with db for DB_CYCLES edges in a row.
   always_comb begin
      w_setMask = 8'h00;
      for (int i = 0; i < 8; i++) begin
         w_setMask[i] = (r_s2[i] != r_db[i]) && (r_cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_db <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (r_s2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_db[i]  <= r_s2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_selData = (mem_cmd == 2'b00) && (mem_addr == SW_ADDR);
      w_selChg  = (mem_cmd == 2'b00) && (mem_addr == CHG_ADDR);
      w_wrChg   = (mem_cmd == 2'b01) && (mem_addr == CHG_ADDR);
      rd_drive  = w_selData | w_selChg;
      if (w_selData) begin
         read_data = r_db;
      end else if (w_selChg) begin
         read_data = r_chg;
      end else begin
         read_data = 8'h00;
      end
   end

   // Clear-on-read drops exactly what the CPU saw; a same-edge set still wins.
   always_comb begin
      w_clrMask = 8'h00;
      if (w_selChg) begin
         w_clrMask = r_chg;
      end else if (w_wrChg) begin
         w_clrMask = write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chg <= 8'h00;
      end else begin
         r_chg <= (r_chg & ~w_clrMask) | w_setMask;
      end
   end

endmodule

// File: tb/tb_mem_mapped_io_sw.sv
// Self-checking bench for mem_mapped_io_sw: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the switch port.
module tb_mem_mapped_io_sw;

   localparam int         DB   = 4;
   localparam logic [8:0] ADDR = 9'h140;

   logic       clk;
   logic       reset;
   logic [7:0] SW;
   logic [8:0] mem_addr;
   logic [1:0] mem_cmd;
   logic [7:0] write_data;
   wire  [7:0] read_data;
   wire        rd_drive;

   int nChecks = 0;
   int nPass   = 0;

   logic [7:0] mS1, mS2, mDb, mChg;
   int         mRun [8];

   mem_mapped_io_sw #(.SW_ADDR(ADDR), .DB_CYCLES(DB), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .SW(SW), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
      .write_data(write_data), .read_data(read_data), .rd_drive(rd_drive)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] expRd();
      if (mem_cmd == 2'b00 && mem_addr == ADDR) return mDb;
      if (mem_cmd == 2'b00 && mem_addr == ADDR + 9'd1) return mChg;
      return 8'h00;
   endfunction

   function automatic logic expDrive();
      return (mem_cmd == 2'b00) && (mem_addr == ADDR || mem_addr == ADDR + 9'd1);
   endfunction

   // Bits whose synchronized level has now disagreed with the accepted level for DB edges.
   function automatic logic [7:0] predSet();
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 8; i++) s[i] = (mS2[i] != mDb[i]) && (mRun[i] + 1 == DB);
      return s;
   endfunction

   task automatic tick();
      logic [7:0] setm, clr;
      if (reset) begin
         mS1 = 0; mS2 = 0; mDb = 0; mChg = 0;
         for (int i = 0; i < 8; i++) mRun[i] = 0;
      end else begin
         setm = predSet();
         clr  = 8'h00;
         if (mem_cmd == 2'b00 && mem_addr == ADDR + 9'd1) clr = mChg;
         else if (mem_cmd == 2'b01 && mem_addr == ADDR + 9'd1) clr = write_data;
         for (int i = 0; i < 8; i++) begin
            if (mS2[i] != mDb[i]) mRun[i]++;
            else mRun[i] = 0;
            if (setm[i]) begin
               mDb[i] = mS2[i];
               mRun[i] = 0;
            end
         end
         mChg = (mChg & ~clr) | setm;
         mS2 = mS1;
         mS1 = SW;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyBus(input logic [1:0] cmd, input logic [8:0] a, input logic [7:0] wd);
      mem_cmd = cmd; mem_addr = a; write_data = wd;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; SW = 8'h00;
      applyBus(2'b11, 9'h000, 8'h00);
      tick(); tick();
      reset = 1'b0;
      applyBus(2'b00, ADDR, 8'h00);
      nChecks++; if (read_data !== 8'h00) $display("[TB] FAIL reset_data: got %h want 00", read_data); else nPass++;
      nChecks++; if (rd_drive !== 1'b1) $display("[TB] FAIL reset_drive: got %b want 1", rd_drive); else nPass++;
      tick();
      applyBus(2'b00, ADDR + 9'd1, 8'h00);
      nChecks++; if (read_data !== 8'h00) $display("[TB] FAIL reset_chg: got %h want 00", read_data); else nPass++;
      tick();
   endtask

   task automatic test_latency();
      SW = 8'hA5;
      applyBus(2'b00, ADDR, 8'h00);
      for (int k = 0; k <= 9; k++) begin
         tick();
         if (k <= 4) begin
            nChecks++; if (read_data !== 8'h00) $display("[TB] FAIL latency_early e%0d: got %h want 00", k, read_data); else nPass++;
         end
         if (k >= 6) begin
            nChecks++; if (read_data !== 8'hA5) $display("[TB] FAIL latency_late e%0d: got %h want a5", k, read_data); else nPass++;
         end
         nChecks++; if (read_data !== expRd()) $display("[TB] FAIL latency_model e%0d: got %h want %h", k, read_data, expRd()); else nPass++;
      end
      applyBus(2'b00, ADDR + 9'd1, 8'h00);
      nChecks++; if (read_data !== 8'hA5) $display("[TB] FAIL chg_first_read: got %h want a5", read_data); else nPass++;
      tick();
      nChecks++; if (read_data !== 8'h00) $display("[TB] FAIL chg_second_read: got %h want 00", read_data); else nPass++;
      tick();
   endtask

   task automatic test_glitch();
      SW = 8'h00;
      applyBus(2'b11, 9'h000, 8'h00);
      for (int k = 0; k < 12; k++) tick();
      applyBus(2'b01, ADDR + 9'd1, 8'hFF);
      tick();
      for (int k = 0; k < 14; k++) begin
         SW = (k < 3) ? 8'h01 : 8'h00;
         applyBus(2'b00, (k % 2 == 0) ? ADDR : ADDR + 9'd1, 8'h00);
         nChecks++; if (read_data !== 8'h00) $display("[TB] FAIL glitch c%0d: got %h want 00", k, read_data); else nPass++;
         tick();
      end
   endtask

   task automatic test_clear_race();
      logic [7:0] ps;
      bit found = 0;
      SW = 8'h01;
      applyBus(2'b11, 9'h000, 8'h00);
      for (int k = 0; k < 12; k++) tick();
      SW = 8'h03;
      for (int k = 0; k < 20 && !found; k++) begin
         ps = predSet();
         if (ps[1]) found = 1;
         else tick();
      end
      nChecks++; if (!found) $display("[TB] FAIL race_timeout: got 0 want 1"); else nPass++;
      applyBus(2'b00, ADDR + 9'd1, 8'h00);
      nChecks++; if (read_data !== 8'h01) $display("[TB] FAIL race_read: got %h want 01", read_data); else nPass++;
      tick();
      nChecks++; if (read_data !== 8'h02) $display("[TB] FAIL race_after: got %h want 02", read_data); else nPass++;
      tick();
   endtask

   task automatic test_w1c();
      SW = 8'hFC;
      applyBus(2'b11, 9'h000, 8'h00);
      for (int k = 0; k < 12; k++) tick();
      applyBus(2'b01, ADDR + 9'd1, 8'h0F);
      nChecks++; if (rd_drive !== 1'b0 || read_data !== 8'h00) $display("[TB] FAIL w1c_bus: got %b/%h want 0/00", rd_drive, read_data); else nPass++;
      tick();
      applyBus(2'b01, ADDR, 8'hFF);
      tick();
      applyBus(2'b00, ADDR, 8'h00);
      nChecks++; if (read_data !== 8'hFC) $display("[TB] FAIL w1c_data_kept: got %h want fc", read_data); else nPass++;
      tick();
      applyBus(2'b00, ADDR + 9'd1, 8'h00);
      nChecks++; if (read_data !== 8'hF0) $display("[TB] FAIL w1c_chg: got %h want f0", read_data); else nPass++;
      tick();
      SW = 8'h03;
      applyBus(2'b11, 9'h000, 8'h00);
      for (int k = 0; k < 12; k++) tick();
   endtask

   task automatic test_noaccess();
      applyBus(2'b10, ADDR, 8'h00);
      nChecks++; if (rd_drive !== 1'b0 || read_data !== 8'h00) $display("[TB] FAIL cmd10: got %b/%h want 0/00", rd_drive, read_data); else nPass++;
      tick();
      applyBus(2'b00, 9'h100, 8'h00);
      nChecks++; if (rd_drive !== 1'b0 || read_data !== 8'h00) $display("[TB] FAIL addr100: got %b/%h want 0/00", rd_drive, read_data); else nPass++;
      tick();
      applyBus(2'b00, ADDR + 9'd1, 8'h00);
      nChecks++; if (read_data !== 8'hFF) $display("[TB] FAIL chg_survives_noaccess: got %h want ff", read_data); else nPass++;
      tick();
   endtask

   task automatic test_reset_mid_debounce();
      SW = 8'hFF;
      applyBus(2'b11, 9'h000, 8'h00);
      for (int k = 0; k < 4; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyBus(2'b00, ADDR, 8'h00);
      nChecks++; if (read_data !== 8'h00) $display("[TB] FAIL midreset_db: got %h want 00", read_data); else nPass++;
      for (int k = 0; k < 10; k++) begin
         tick();
         nChecks++; if (read_data !== expRd()) $display("[TB] FAIL midreset_model c%0d: got %h want %h", k, read_data, expRd()); else nPass++;
      end
      nChecks++; if (read_data !== 8'hFF) $display("[TB] FAIL midreset_requal: got %h want ff", read_data); else nPass++;
      tick();
   endtask

   task automatic test_random();
      logic [8:0] addrs [4];
      addrs[0] = ADDR; addrs[1] = ADDR + 9'd1; addrs[2] = 9'h100; addrs[3] = ADDR + 9'd2;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(5) == 0) SW = 8'($urandom);
         reset = ($urandom_range(99) == 0);
         applyBus(2'($urandom_range(3)), addrs[$urandom_range(3)], 8'($urandom));
         nChecks++; if (read_data !== expRd()) $display("[TB] FAIL rand_data c%0d: got %h want %h", k, read_data, expRd()); else nPass++;
         nChecks++; if (rd_drive !== expDrive()) $display("[TB] FAIL rand_drive c%0d: got %b want %b", k, rd_drive, expDrive()); else nPass++;
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      mS1 = 0; mS2 = 0; mDb = 0; mChg = 0;
      for (int i = 0; i < 8; i++) mRun[i] = 0;
      test_reset();
      test_latency();
      test_glitch();
      test_clear_race();
      test_w1c();
      test_noaccess();
      test_reset_mid_debounce();
      test_random();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
